// File: rtl/elastic_pipe.sv
// elastic_pipe: WIDTH-bit, DEPTH-stage valid/ready pipeline built from two-entry skid slices.
// Optional synchronous flush input is enabled by defining ELASTIC_PIPE_FLUSH_EN.
module elastic_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef ELASTIC_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  output logic [CW-1:0]    occupancy
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("elastic_pipe: DEPTH must be at least 1");
    end
  endgenerate

  // Chain index i is the input side of slice i; index DEPTH is the pipe output.
  logic [DEPTH:0]   vld_chain_s;
  logic [DEPTH:0]   rdy_chain_s;
  logic [WIDTH-1:0] dat_chain_s [DEPTH+1];
  logic             flush_s;
  logic             in_hs_s;
  logic             out_hs_s;
  logic [CW-1:0]    occ_nxt_s;
  logic [CW-1:0]    occ_r;

`ifdef ELASTIC_PIPE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign vld_chain_s[0]     = in_valid;
  assign dat_chain_s[0]     = in_data;
  assign rdy_chain_s[DEPTH] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slice
      logic             m_v_r;
      logic [WIDTH-1:0] m_d_r;
      logic             s_v_r;
      logic [WIDTH-1:0] s_d_r;
      logic             acc_s;
      logic             main_free_s;

      // Accept only while the skid is empty; main is free when empty or draining.
      always_comb begin
        acc_s       = vld_chain_s[gi] & ~s_v_r;
        main_free_s = ~m_v_r | rdy_chain_s[gi+1];
      end

      // Slice state: refill main from skid first, then from upstream; park in skid otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          m_v_r <= 1'b0;
          m_d_r <= '0;
          s_v_r <= 1'b0;
          s_d_r <= '0;
        end else if (flush_s) begin
          m_v_r <= 1'b0;
          s_v_r <= 1'b0;
        end else if (main_free_s) begin
          if (s_v_r) begin
            m_v_r <= 1'b1;
            m_d_r <= s_d_r;
            s_v_r <= 1'b0;
          end else if (acc_s) begin
            m_v_r <= 1'b1;
            m_d_r <= dat_chain_s[gi];
          end else begin
            m_v_r <= 1'b0;
          end
        end else if (acc_s) begin
          s_v_r <= 1'b1;
          s_d_r <= dat_chain_s[gi];
        end else begin
          s_v_r <= s_v_r;
        end
      end

      assign rdy_chain_s[gi]   = ~s_v_r;
      assign vld_chain_s[gi+1] = m_v_r;
      assign dat_chain_s[gi+1] = m_d_r;
    end
  endgenerate

  assign in_ready  = rdy_chain_s[0];
  assign out_valid = vld_chain_s[DEPTH];
  assign out_data  = dat_chain_s[DEPTH];

  // Occupancy next-state: simultaneous in/out handshakes cancel out.
  always_comb begin
    in_hs_s  = in_valid & rdy_chain_s[0];
    out_hs_s = vld_chain_s[DEPTH] & out_ready;
    if (flush_s) begin
      occ_nxt_s = '0;
    end else if (in_hs_s && !out_hs_s) begin
      occ_nxt_s = occ_r + CW'(1);
    end else if (!in_hs_s && out_hs_s) begin
      occ_nxt_s = occ_r - CW'(1);
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r <= '0;
    end else begin
      occ_r <= occ_nxt_s;
    end
  end

  assign occupancy = occ_r;

endmodule
